// File: rtl/clock_divider_multi.sv
// clock_divider_multi: independent programmable clock dividers on one clock.
// Each channel has a toggle mode and a pulse mode. New settings wait for a period boundary.
// Ports:
//   clk_in, rst       - clock and asynchronous active-high reset
//   cfg_valid/ready   - handshake that loads a channel's shadow config
//   cfg_chan/scale/mode - target channel, new divisor S, and mode (0 toggle, 1 pulse)
//   restart           - re-phases all channels at the same time
//   clk_out, pending  - divided outputs and per-channel shadow-waiting flags
module clock_divider_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int RESET_SCALE = 0,
  parameter int RESET_MODE  = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [WIDTH-1:0]    cfg_scale,
  input  logic                cfg_mode,
  input  logic                restart,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] pending
);

  // Channels with no decode match (out of range) always accept.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CW'(i)) cfg_ready = !pending[i];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] sh_s_q;
    logic             mode_q;
    logic             sh_mode_q;
    logic             pend_q;
    logic             out_q;
    logic             acc;
    logic             run;
    logic             bnd;

    assign acc = cfg_valid && cfg_ready && (cfg_chan == CW'(i));
    assign run = (s_q != '0);
    assign bnd = run && (cnt_q == s_q - 1'b1);

    assign clk_out[i] = out_q;
    assign pending[i] = pend_q;

    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        s_q       <= WIDTH'(RESET_SCALE);
        mode_q    <= 1'(RESET_MODE);
        cnt_q     <= '0;
        sh_s_q    <= '0;
        sh_mode_q <= 1'b0;
        pend_q    <= 1'b0;
        out_q     <= 1'b0;
      end else if (restart) begin
        // A fresh accept and a pending shadow cannot coexist (ready is low).
        cnt_q  <= '0;
        out_q  <= 1'b0;
        pend_q <= 1'b0;
        if (acc) begin
          s_q    <= cfg_scale;
          mode_q <= cfg_mode;
        end else if (pend_q) begin
          s_q    <= sh_s_q;
          mode_q <= sh_mode_q;
        end
      end else if (!run) begin
        cnt_q <= '0;
        out_q <= 1'b0;
        if (pend_q) begin
          s_q    <= sh_s_q;
          mode_q <= sh_mode_q;
          pend_q <= 1'b0;
        end else if (acc) begin
          sh_s_q    <= cfg_scale;
          sh_mode_q <= cfg_mode;
          pend_q    <= 1'b1;
        end
      end else if (bnd) begin
        cnt_q <= '0;
        if (pend_q) begin
          s_q    <= sh_s_q;
          mode_q <= sh_mode_q;
          pend_q <= 1'b0;
          if (sh_mode_q != mode_q || sh_s_q == '0) out_q <= 1'b0;
          else out_q <= mode_q ? 1'b1 : ~out_q;
        end else begin
          out_q <= mode_q ? 1'b1 : ~out_q;
          // Accepted on a boundary: held for the following one.
          if (acc) begin
            sh_s_q    <= cfg_scale;
            sh_mode_q <= cfg_mode;
            pend_q    <= 1'b1;
          end
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
        if (mode_q) out_q <= 1'b0;
        if (acc) begin
          sh_s_q    <= cfg_scale;
          sh_mode_q <= cfg_mode;
          pend_q    <= 1'b1;
        end
      end
    end
  end

endmodule
